// File: rtl/ps2_codes_pkg.sv
// PS/2 scancodes, prefix FSM states and direction encoding shared by the
// direction decoder and its per-player trackers.
package ps2_codes_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_P = 8'h4D;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } dir_sel_t;

    localparam dir_sel_t DIR_NONE = '{valid: 1'b0, dir: DIR_UP};

    function automatic dir_sel_t decode_normal(input logic [7:0] code);
        case (code)
            KEY_W:   return '{valid: 1'b1, dir: DIR_UP};
            KEY_D:   return '{valid: 1'b1, dir: DIR_RIGHT};
            KEY_S:   return '{valid: 1'b1, dir: DIR_DOWN};
            KEY_A:   return '{valid: 1'b1, dir: DIR_LEFT};
            default: return DIR_NONE;
        endcase
    endfunction

    function automatic dir_sel_t decode_ext(input logic [7:0] code);
        case (code)
            KEY_UP:    return '{valid: 1'b1, dir: DIR_UP};
            KEY_RIGHT: return '{valid: 1'b1, dir: DIR_RIGHT};
            KEY_DOWN:  return '{valid: 1'b1, dir: DIR_DOWN};
            KEY_LEFT:  return '{valid: 1'b1, dir: DIR_LEFT};
            default:   return DIR_NONE;
        endcase
    endfunction

    // Priority up > right > down > left when activity falls back to a held key.
    function automatic dir_sel_t highest_held(input logic [3:0] held);
        if (held[DIR_UP])         return '{valid: 1'b1, dir: DIR_UP};
        else if (held[DIR_RIGHT]) return '{valid: 1'b1, dir: DIR_RIGHT};
        else if (held[DIR_DOWN])  return '{valid: 1'b1, dir: DIR_DOWN};
        else if (held[DIR_LEFT])  return '{valid: 1'b1, dir: DIR_LEFT};
        else                      return DIR_NONE;
    endfunction

endpackage

// File: rtl/player_dir_tracker.sv
// Held flags and active-direction tracking for one player; outputs are
// registered and either one-hot (newest press wins) or the raw held flags.
module player_dir_tracker
    import ps2_codes_pkg::*;
#(
    parameter bit ONE_HOT = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic make,
    input  logic brk,
    input  dir_t dir,
    output logic up,
    output logic right,
    output logic down,
    output logic left
);

    logic [3:0] held, held_nxt;
    dir_sel_t   active, active_nxt;
    logic [3:0] out_nxt;

    always_comb begin
        held_nxt   = held;
        active_nxt = active;
        out_nxt    = '0;
        if (make) begin
            held_nxt[dir] = 1'b1;
            active_nxt    = '{valid: 1'b1, dir: dir};
        end else if (brk && held[dir]) begin
            held_nxt[dir] = 1'b0;
            if (active.valid && active.dir == dir)
                active_nxt = highest_held(held_nxt);
        end
        if (ONE_HOT) begin
            if (active_nxt.valid)
                out_nxt[active_nxt.dir] = 1'b1;
        end else begin
            out_nxt = held_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held   <= '0;
            active <= DIR_NONE;
            up     <= 1'b0;
            right  <= 1'b0;
            down   <= 1'b0;
            left   <= 1'b0;
        end else begin
            held   <= held_nxt;
            active <= active_nxt;
            up     <= out_nxt[DIR_UP];
            right  <= out_nxt[DIR_RIGHT];
            down   <= out_nxt[DIR_DOWN];
            left   <= out_nxt[DIR_LEFT];
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Turns the PS/2 byte stream into held direction levels for two players
// plus a pause toggle, tracking E0/F0 prefixes with a timeout.
module ps2_direction_decoder
    import ps2_codes_pkg::*;
#(
    parameter bit          ONE_HOT        = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic       upSig2,
    output logic       rightSig2,
    output logic       downSig2,
    output logic       leftSig2,
    output logic       pauseButton
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    logic          key_prev;
    logic          accept;
    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          p_held;
    logic          do_make, do_brk, is_ext;
    dir_sel_t      norm_sel, ext_sel;

    assign accept   = ps2_key_pressed && !key_prev;
    assign norm_sel = decode_normal(ps2_out);
    assign ext_sel  = decode_ext(ps2_out);

    always_comb begin
        do_make = 1'b0;
        do_brk  = 1'b0;
        is_ext  = 1'b0;
        if (accept && ps2_out != SC_EXT && ps2_out != SC_BRK) begin
            case (state)
                ST_IDLE:    do_make = 1'b1;
                ST_BRK:     do_brk  = 1'b1;
                ST_EXT:     begin do_make = 1'b1; is_ext = 1'b1; end
                ST_EXT_BRK: begin do_brk  = 1'b1; is_ext = 1'b1; end
                default:    ;
            endcase
        end
    end

    // An accepted byte takes precedence over a timeout reached on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_prev    <= 1'b0;
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            p_held      <= 1'b0;
            pauseButton <= 1'b0;
        end else begin
            key_prev <= ps2_key_pressed;
            if (accept) begin
                tmo_cnt <= '0;
                if (ps2_out == SC_EXT) begin
                    state <= ST_EXT;
                end else if (ps2_out == SC_BRK) begin
                    case (state)
                        ST_IDLE: state <= ST_BRK;
                        ST_EXT:  state <= ST_EXT_BRK;
                        default: state <= state;
                    endcase
                end else begin
                    state <= ST_IDLE;
                end
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TMAX) begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            if (do_make && !is_ext && ps2_out == KEY_P) begin
                if (!p_held)
                    pauseButton <= ~pauseButton;
                p_held <= 1'b1;
            end else if (do_brk && !is_ext && ps2_out == KEY_P) begin
                p_held <= 1'b0;
            end
        end
    end

    player_dir_tracker #(.ONE_HOT(ONE_HOT)) u_player0 (
        .clock (clock),
        .reset (reset),
        .make  (do_make && !is_ext && norm_sel.valid),
        .brk   (do_brk && !is_ext && norm_sel.valid),
        .dir   (norm_sel.dir),
        .up    (upSig),
        .right (rightSig),
        .down  (downSig),
        .left  (leftSig)
    );

    player_dir_tracker #(.ONE_HOT(ONE_HOT)) u_player1 (
        .clock (clock),
        .reset (reset),
        .make  (do_make && is_ext && ext_sel.valid),
        .brk   (do_brk && is_ext && ext_sel.valid),
        .dir   (ext_sel.dir),
        .up    (upSig2),
        .right (rightSig2),
        .down  (downSig2),
        .left  (leftSig2)
    );

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: one-hot and raw instances share stimulus;
// outputs packed as {pause, up2,right2,down2,left2, up,right,down,left}.
module tb_ps2_direction_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       strobe;
    logic [7:0] code;

    logic oh_u, oh_r, oh_d, oh_l, oh_u2, oh_r2, oh_d2, oh_l2, oh_p;
    logic rw_u, rw_r, rw_d, rw_l, rw_u2, rw_r2, rw_d2, rw_l2, rw_p;
    logic [8:0] out_oh, out_raw;

    assign out_oh  = {oh_p, oh_u2, oh_r2, oh_d2, oh_l2, oh_u, oh_r, oh_d, oh_l};
    assign out_raw = {rw_p, rw_u2, rw_r2, rw_d2, rw_l2, rw_u, rw_r, rw_d, rw_l};

    always #5 clock = ~clock;

    ps2_direction_decoder #(.ONE_HOT(1'b1), .TIMEOUT_CYCLES(10)) u_dut_oh (
        .clock(clock), .reset(reset), .ps2_key_pressed(strobe), .ps2_out(code),
        .upSig(oh_u), .rightSig(oh_r), .downSig(oh_d), .leftSig(oh_l),
        .upSig2(oh_u2), .rightSig2(oh_r2), .downSig2(oh_d2), .leftSig2(oh_l2),
        .pauseButton(oh_p)
    );

    ps2_direction_decoder #(.ONE_HOT(1'b0), .TIMEOUT_CYCLES(10)) u_dut_raw (
        .clock(clock), .reset(reset), .ps2_key_pressed(strobe), .ps2_out(code),
        .upSig(rw_u), .rightSig(rw_r), .downSig(rw_d), .leftSig(rw_l),
        .upSig2(rw_u2), .rightSig2(rw_r2), .downSig2(rw_d2), .leftSig2(rw_l2),
        .pauseButton(rw_p)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0] oh;
        logic [8:0] raw;
        string      name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] code;
        int         hold;
        logic [8:0] oh;
        logic [8:0] raw;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %03h expected %03h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the gap.
    task automatic send(input logic [7:0] c, input int hold, input int gap,
                        input logic [8:0] oh, input logic [8:0] raw, input string name);
        exp_t e;
        strobe = 1'b1;
        code   = c;
        sb.push_back('{oh: oh, raw: raw, name: name});
        @(posedge clock); #1;
        e = sb.pop_front();
        check({e.name, " oh"}, out_oh, e.oh);
        check({e.name, " raw"}, out_raw, e.raw);
        for (int i = 1; i < hold; i++) begin
            @(posedge clock); #1;
            check({e.name, " hold oh"}, out_oh, e.oh);
            check({e.name, " hold raw"}, out_raw, e.raw);
        end
        strobe = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic addv(input logic [7:0] c, input int hold, input logic [8:0] oh, input logic [8:0] raw);
        vecs.push_back('{code: c, hold: hold, oh: oh, raw: raw});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset  = 1'b1;
        strobe = 1'b0;
        code   = 8'h00;

        addv(8'h1D,1,9'h008,9'h008); addv(8'hF0,1,9'h008,9'h008); addv(8'h1D,1,9'h000,9'h000);
        addv(8'hE0,1,9'h000,9'h000); addv(8'h75,1,9'h080,9'h080);
        addv(8'hE0,1,9'h080,9'h080); addv(8'h6B,1,9'h010,9'h090);
        addv(8'hE0,1,9'h010,9'h090); addv(8'hF0,1,9'h010,9'h090); addv(8'h6B,1,9'h080,9'h080);
        addv(8'hE0,1,9'h080,9'h080); addv(8'hF0,1,9'h080,9'h080); addv(8'h75,1,9'h000,9'h000);
        addv(8'h4D,1,9'h100,9'h100); addv(8'h4D,1,9'h100,9'h100); addv(8'h4D,1,9'h100,9'h100);
        addv(8'hF0,1,9'h100,9'h100); addv(8'h4D,1,9'h100,9'h100); addv(8'h4D,1,9'h000,9'h000);
        addv(8'hF0,1,9'h000,9'h000); addv(8'h4D,1,9'h000,9'h000);
        addv(8'h1D,1,9'h008,9'h008); addv(8'h1C,1,9'h001,9'h009); addv(8'h1B,1,9'h002,9'h00B);
        addv(8'hF0,1,9'h002,9'h00B); addv(8'h1D,1,9'h002,9'h003);
        addv(8'hF0,1,9'h002,9'h003); addv(8'h1B,1,9'h001,9'h001);
        addv(8'hF0,1,9'h001,9'h001); addv(8'h1C,1,9'h000,9'h000);
        addv(8'hE0,1,9'h000,9'h000); addv(8'h1D,1,9'h000,9'h000);
        addv(8'h75,1,9'h000,9'h000);
        addv(8'hF0,1,9'h000,9'h000); addv(8'h23,1,9'h000,9'h000);
        addv(8'h23,5,9'h004,9'h004); addv(8'hF0,1,9'h004,9'h004); addv(8'h23,1,9'h000,9'h000);
        addv(8'h1D,1,9'h008,9'h008); addv(8'hF0,1,9'h008,9'h008); addv(8'h1D,5,9'h000,9'h000);
        addv(8'h1D,1,9'h008,9'h008); addv(8'hE0,1,9'h008,9'h008); addv(8'h74,1,9'h048,9'h048);
        addv(8'hF0,1,9'h048,9'h048); addv(8'h1D,1,9'h040,9'h040);
        addv(8'hE0,1,9'h040,9'h040); addv(8'hF0,1,9'h040,9'h040); addv(8'h74,1,9'h000,9'h000);
        addv(8'h1D,1,9'h008,9'h008); addv(8'h1C,1,9'h001,9'h009);
        addv(8'hF0,1,9'h001,9'h009); addv(8'h1C,1,9'h008,9'h008);
        addv(8'hF0,1,9'h008,9'h008); addv(8'h1D,1,9'h000,9'h000);

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset oh", out_oh, 9'h000);
        check("reset raw", out_raw, 9'h000);

        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].code, vecs[i].hold, 2, vecs[i].oh, vecs[i].raw, $sformatf("vec%0d", i));

        // Timeout boundary: byte on the timeout edge is still a break, one later is a make.
        send(8'h1C, 1, 2,  9'h001, 9'h001, "to_make");
        send(8'hF0, 1, 10, 9'h001, 9'h001, "to_f0_a");
        send(8'h1C, 1, 2,  9'h000, 9'h000, "to_brk_on_edge");
        send(8'hF0, 1, 11, 9'h000, 9'h000, "to_f0_b");
        send(8'h1C, 1, 2,  9'h001, 9'h001, "to_expired_make");
        send(8'hF0, 1, 2,  9'h001, 9'h001, "to_f0_c");
        send(8'h1C, 1, 2,  9'h000, 9'h000, "to_clean");
        send(8'hE0, 1, 11, 9'h000, 9'h000, "to_e0");
        send(8'h75, 1, 2,  9'h000, 9'h000, "to_ext_expired");

        send(8'hE0, 1, 2, 9'h000, 9'h000, "rst_e0");
        pulse_reset();
        check("rst_mid oh", out_oh, 9'h000);
        send(8'h75, 1, 2, 9'h000, 9'h000, "rst_75");

        send(8'h1D, 1, 2, 9'h008, 9'h008, "rst_hold_w");
        send(8'h4D, 1, 2, 9'h108, 9'h108, "rst_hold_p");
        pulse_reset();
        check("rst_held oh", out_oh, 9'h000);
        check("rst_held raw", out_raw, 9'h000);
        send(8'hF0, 1, 2, 9'h000, 9'h000, "rst_f0");
        send(8'h1D, 1, 2, 9'h000, 9'h000, "rst_brk_noop");
        send(8'h4D, 1, 2, 9'h100, 9'h100, "rst_p_fresh");

        // Strobe already high when reset releases is a rising edge.
        reset  = 1'b1;
        strobe = 1'b1;
        code   = 8'h1D;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.push_back('{oh: 9'h008, raw: 9'h008, name: "post_rst_strobe"});
        @(posedge clock); #1;
        e = sb.pop_front();
        check({e.name, " oh"}, out_oh, e.oh);
        check({e.name, " raw"}, out_raw, e.raw);
        strobe = 1'b0;
        @(posedge clock); #1;

        check("sb_empty", 9'(sb.size()), 9'h000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
